waveform_shaper: RTL and testbench

Per-channel waveform stage that consumes the 16-bit DDS phase stream and its once-per-sample valid pulse from the phase accumulator. It converts each phase word to a square, saw, triangle or noise sample, applies a 4-bit volume, and emits a signed 8-bit sample with a valid strobe toward the channel mixer. Configuration arrives over the same data/addr/valid register-write bus that programs the phase increment. The block decodes only its own address.

---
 rtl/waveform_shaper_pkg.sv | 42 ++++
 rtl/noise_lfsr.sv | 39 +++
 rtl/waveform_shaper.sv | 104 ++++++++++
 tb/tb_waveform_shaper.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/waveform_shaper_pkg.sv
// Tone-generator shared types and constants:
// wave encodings, config fields, LFSR setup.
package waveform_shaper_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_NOISE  = 2'd3
  } wave_e;

  localparam int WAVE_LSB = 0;
  localparam int VOL_LSB  = 4;
  localparam int DUTY_LSB = 8;

  localparam int LFSR_W = 15;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF;
  localparam int LFSR_TAP_A = 14;
  localparam int LFSR_TAP_B = 13;

  localparam logic [7:0] DEFAULT_DUTY = 8'h80;

  typedef struct packed {
    logic [7:0] duty;
    logic [3:0] vol;
    wave_e      wave;
  } cfg_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] raw;
    logic [3:0] vol;
  } s1_t;

  function automatic logic [7:0] tri_shape(
    input logic [7:0] p
  );
    return p[7] ? ~{p[6:0], 1'b0}
                : {p[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/noise_lfsr.sv
// Noise source: 15-bit LFSR stepped on phase wrap.
// Ports: clk_i, rst_i, strobe_i, msb_i -> bit_o.
module noise_lfsr
  import waveform_shaper_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  input  logic msb_i,
  output logic bit_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              prev_msb_q, prev_msb_d;
  logic              step;

  // A wrap is the phase MSB falling between strobes.
  always_comb begin
    step       = strobe_i && !msb_i && prev_msb_q;
    prev_msb_d = strobe_i ? msb_i : prev_msb_q;
    lfsr_d     = lfsr_q;
    if (step)
      lfsr_d = {lfsr_q[LFSR_W-2:0],
                lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q     <= LFSR_SEED;
      prev_msb_q <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      prev_msb_q <= prev_msb_d;
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/waveform_shaper.sv
// Per-channel phase-to-sample shaper with volume, 2-stage pipe.
// In: phase_in/phase_valid_in, config bus; Out: sample_out/data_valid_out.
module waveform_shaper
  import waveform_shaper_pkg::*;
#(
  parameter logic [3:0] REG_ADDR = 4'h1
)(
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [15:0] phase_in,
  input  logic        phase_valid_in,
  input  logic [15:0] data_in,
  input  logic [3:0]  addr_in,
  input  logic        data_valid_in,
  output logic [7:0]  sample_out,
  output logic        data_valid_out
);

  cfg_t cfg_q, cfg_d;
  s1_t  s1_q, s1_d;

  logic [7:0] sample_q, sample_d;
  logic       valid_q;
  logic       noise_bit;
  logic [7:0] p;
  logic [7:0] raw;
  logic [7:0] s;

  logic signed [11:0] s_ext;
  logic signed [11:0] vol_ext;
  logic signed [11:0] prod;

  logic unused_bits;
  assign unused_bits = ^{phase_in[7:0], data_in[3:2]};

  noise_lfsr u_lfsr (
    .clk_i    (clk_in),
    .rst_i    (reset_in),
    .strobe_i (phase_valid_in),
    .msb_i    (phase_in[15]),
    .bit_o    (noise_bit)
  );

  always_comb begin
    cfg_d = cfg_q;
    if (data_valid_in && addr_in == REG_ADDR) begin
      cfg_d.wave = wave_e'(data_in[WAVE_LSB +: 2]);
      cfg_d.vol  = data_in[VOL_LSB +: 4];
      cfg_d.duty = data_in[DUTY_LSB +: 8];
    end
  end

  assign p = phase_in[15:8];

  always_comb begin
    raw = 8'h00;
    unique case (cfg_q.wave)
      WAVE_SQUARE: raw = (p < cfg_q.duty) ? 8'hFF : 8'h00;
      WAVE_SAW:    raw = p;
      WAVE_TRI:    raw = tri_shape(p);
      WAVE_NOISE:  raw = noise_bit ? 8'hFF : 8'h00;
      default:     raw = 8'h00;
    endcase
  end

  // Stage 1 captures vol with the sample so later
  // config writes never touch in-flight data.
  always_comb begin
    s1_d.valid = phase_valid_in;
    s1_d.raw   = raw;
    s1_d.vol   = cfg_q.vol;
  end

  // Offset-binary to signed, scale, floor-shift by 4.
  always_comb begin
    s        = s1_q.raw ^ 8'h80;
    s_ext    = {{4{s[7]}}, s};
    vol_ext  = {8'h00, s1_q.vol};
    prod     = s_ext * vol_ext;
    sample_d = sample_q;
    if (s1_q.valid)
      sample_d = prod[11:4];
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cfg_q    <= '{duty: DEFAULT_DUTY,
                    vol:  4'h0,
                    wave: WAVE_SQUARE};
      s1_q     <= '0;
      sample_q <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      s1_q     <= s1_d;
      sample_q <= sample_d;
      valid_q  <= s1_q.valid;
    end
  end

  assign sample_out     = sample_q;
  assign data_valid_out = valid_q;

endmodule

// File: tb/tb_waveform_shaper.sv
// Directed bench for waveform_shaper: vector table
// plus hand sequences for pipeline corner cases.
module tb_waveform_shaper;

  localparam logic [3:0] ADDR = 4'h1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] phase;
  logic        pv;
  logic [15:0] data;
  logic [3:0]  addr;
  logic        dv;
  logic [7:0]  sample;
  logic        vout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  waveform_shaper #(.REG_ADDR(ADDR)) dut (
    .clk_in         (clk),
    .reset_in       (rst),
    .phase_in       (phase),
    .phase_valid_in (pv),
    .data_in        (data),
    .addr_in        (addr),
    .data_valid_in  (dv),
    .sample_out     (sample),
    .data_valid_out (vout)
  );

  typedef struct {
    logic [1:0]  wave;
    logic [3:0]  vol;
    logic [7:0]  duty;
    logic [15:0] phase;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %02h want %02h",
               nm, got, want);
    end
  endtask

  task automatic cfg(input logic [1:0] w,
                     input logic [3:0] v,
                     input logic [7:0] d);
    dv   = 1'b1;
    addr = ADDR;
    data = {d, v, 2'b00, w};
    tick();
    dv   = 1'b0;
  endtask

  // Strobe one phase, expect pulse only at T+2.
  task automatic strobe(input string nm,
                        input logic [15:0] ph,
                        input logic [7:0] want);
    pv    = 1'b1;
    phase = ph;
    tick();
    pv = 1'b0;
    chk({nm, "_v1"}, {7'd0, vout}, 8'd0);
    tick();
    chk({nm, "_v2"}, {7'd0, vout}, 8'd1);
    chk(nm, sample, want);
    tick();
    chk({nm, "_v3"}, {7'd0, vout}, 8'd0);
  endtask

  initial begin
    vecs[0]  = '{2'd1, 4'd15, 8'h80, 16'h4000, 8'hC4};
    vecs[1]  = '{2'd2, 4'd15, 8'h80, 16'hC000, 8'hFF};
    vecs[2]  = '{2'd0, 4'd8,  8'h80, 16'h0000, 8'h3F};
    vecs[3]  = '{2'd0, 4'd8,  8'h80, 16'h8000, 8'hC0};
    vecs[4]  = '{2'd0, 4'd8,  8'h00, 16'h1234, 8'hC0};
    vecs[5]  = '{2'd1, 4'd0,  8'h80, 16'h7F00, 8'h00};
    vecs[6]  = '{2'd2, 4'd15, 8'h80, 16'h7F00, 8'h76};
    vecs[7]  = '{2'd2, 4'd15, 8'h80, 16'h8000, 8'h77};
    vecs[8]  = '{2'd2, 4'd15, 8'h80, 16'hFF00, 8'h88};
    vecs[9]  = '{2'd1, 4'd1,  8'h80, 16'h0000, 8'hF8};
    vecs[10] = '{2'd1, 4'd15, 8'h80, 16'hFF00, 8'h77};
    vecs[11] = '{2'd0, 4'd15, 8'hFF, 16'hFF00, 8'h88};
    vecs[12] = '{2'd0, 4'd15, 8'hFF, 16'hFE00, 8'h77};

    rst = 1'b1; pv = 1'b0; dv = 1'b0;
    phase = '0; data = '0; addr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_sample", sample, 8'h00);
    chk("rst_valid", {7'd0, vout}, 8'd0);

    // Noise from seed; wrap on 2nd strobe, seen on 3rd.
    cfg(2'd3, 4'd15, 8'h80);
    strobe("noise0", 16'h9000, 8'h77);
    strobe("noise1", 16'h1000, 8'h77);
    strobe("noise2", 16'h2000, 8'h88);

    for (int i = 0; i < 13; i++) begin
      cfg(vecs[i].wave, vecs[i].vol, vecs[i].duty);
      strobe($sformatf("vec%0d", i),
             vecs[i].phase, vecs[i].exp);
    end

    // Config write alongside a strobe.
    cfg(2'd1, 4'd15, 8'h80);
    pv = 1'b1; phase = 16'h4000;
    dv = 1'b1; addr = ADDR; data = 16'h0001;
    tick();
    pv = 1'b0; dv = 1'b0;
    tick();
    chk("same_cyc_v", {7'd0, vout}, 8'd1);
    chk("same_cyc_old", sample, 8'hC4);
    tick();
    strobe("same_cyc_new", 16'h4000, 8'h00);

    // Foreign addresses and idle bus ignored.
    cfg(2'd1, 4'd15, 8'h80);
    dv = 1'b1; addr = 4'h2; data = 16'h0000;
    tick();
    addr = 4'h0;
    tick();
    dv = 1'b0; addr = ADDR;
    tick();
    strobe("bad_addr", 16'h4000, 8'hC4);

    // Four back-to-back strobes.
    pv = 1'b1; phase = 16'h0000;
    tick();
    phase = 16'h4000;
    chk("b2b_v1", {7'd0, vout}, 8'd0);
    tick();
    phase = 16'h8000;
    chk("b2b_v2", {7'd0, vout}, 8'd1);
    chk("b2b_0", sample, 8'h88);
    tick();
    phase = 16'hC000;
    chk("b2b_v3", {7'd0, vout}, 8'd1);
    chk("b2b_1", sample, 8'hC4);
    tick();
    pv = 1'b0;
    chk("b2b_v4", {7'd0, vout}, 8'd1);
    chk("b2b_2", sample, 8'h00);
    tick();
    chk("b2b_v5", {7'd0, vout}, 8'd1);
    chk("b2b_3", sample, 8'h3C);
    tick();
    chk("b2b_v6", {7'd0, vout}, 8'd0);

    // Reset at T+1 flushes the pipe and config.
    pv = 1'b1; phase = 16'h4000;
    tick();
    pv = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_v", {7'd0, vout}, 8'd0);
    chk("mid_rst_s", sample, 8'h00);
    tick();
    chk("mid_rst_v2", {7'd0, vout}, 8'd0);
    strobe("mid_rst_cfg", 16'h4000, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
